// File: rtl/sd_dac_multi.sv
`default_nettype none
// ============================================================================
//  Module   : sd_dac_multi
//  Function : Multi-channel sigma-delta audio DAC. PCM frames enter a one-deep
//             buffer over valid/ready. An oversampling counter moves the buffer
//             into the active sample once per sample period. Each channel runs
//             a first- or second-order saturating modulator that drives one
//             1-bit output pin.
//  Revision : 1.0  initial release
// ============================================================================
module sd_dac_multi #(
  parameter int BITDEPTH = 12,
  parameter int NCHAN    = 2,
  parameter int ORDER    = 2,
  parameter int OSR      = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic                      pcm_valid_i,
  output logic                      pcm_ready_o,
  input  logic [NCHAN*BITDEPTH-1:0] pcm_data_i,
  output logic                      underrun_o,
  input  logic                      underrun_clr_i,
  output logic [NCHAN-1:0]          out_o
);

  localparam int c_CW = (OSR > 2) ? $clog2(OSR) : 1;
  localparam int c_FW = NCHAN * BITDEPTH;
  localparam int c_W1 = BITDEPTH + 2;
  localparam int c_W2 = BITDEPTH + 4;
  // Sum width: wide enough that i2 + i1 - fb can never overflow before clamping
  localparam int c_SW = BITDEPTH + 6;

  localparam logic [c_CW-1:0]        c_OCNT_LAST = c_CW'(OSR - 1);
  localparam logic signed [c_SW-1:0] c_H         = c_SW'(1 << (BITDEPTH - 1));
  localparam logic signed [c_SW-1:0] c_I1_MAX    = c_SW'((1 << (c_W1 - 1)) - 1);
  localparam logic signed [c_SW-1:0] c_I1_MIN    = ~c_I1_MAX;
  localparam logic signed [c_SW-1:0] c_I2_MAX    = c_SW'((1 << (c_W2 - 1)) - 1);
  localparam logic signed [c_SW-1:0] c_I2_MIN    = ~c_I2_MAX;

  if ((ORDER != 1) && (ORDER != 2)) begin : g_bad_order
    $error("sd_dac_multi: ORDER must be 1 or 2");
  end
  if (OSR < 2) begin : g_bad_osr
    $error("sd_dac_multi: OSR must be at least 2");
  end

  logic [c_CW-1:0] ocnt_q, ocnt_d;
  logic [c_FW-1:0] pend_q, pend_d;
  logic [c_FW-1:0] act_q, act_d;
  logic            pend_full_q, pend_full_d;
  logic            underrun_q, underrun_d;
  logic            w_tick;
  logic            w_accept;

  assign w_tick      = en_i && (ocnt_q == c_OCNT_LAST);
  assign w_accept    = pcm_valid_i && !pend_full_q;
  assign pcm_ready_o = ~pend_full_q;
  assign underrun_o  = underrun_q;

  // Frame buffer, sample tick and underrun next-state
  always_comb begin
    ocnt_d      = ocnt_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    act_d       = act_q;
    underrun_d  = underrun_q;
    if (en_i) begin
      ocnt_d = w_tick ? '0 : ocnt_q + 1'b1;
    end
    if (w_tick) begin
      if (pend_full_q) begin
        act_d       = pend_q;
        pend_full_d = 1'b0;
      end else if (w_accept) begin
        // Frame arriving exactly on the tick bypasses the buffer
        act_d = pcm_data_i;
      end
    end else if (w_accept) begin
      pend_d      = pcm_data_i;
      pend_full_d = 1'b1;
    end
    // A new underrun takes priority over a clear in the same cycle
    if (w_tick && !pend_full_q && !w_accept) begin
      underrun_d = 1'b1;
    end else if (underrun_clr_i) begin
      underrun_d = 1'b0;
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ocnt_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      act_q       <= '0;
      underrun_q  <= 1'b0;
    end else begin
      ocnt_q      <= ocnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      act_q       <= act_d;
      underrun_q  <= underrun_d;
    end
  end

  for (genvar k = 0; k < NCHAN; k++) begin : g_chan
    logic signed [c_W1-1:0] i1_q, i1_d;
    logic signed [c_W2-1:0] i2_q, i2_d;
    logic                   out_q, out_d;
    logic signed [c_SW-1:0] w_x, w_fb, w_s1, w_s2, w_c1, w_c2;

    assign w_x  = {{(c_SW-BITDEPTH){act_q[k*BITDEPTH+BITDEPTH-1]}},
                   act_q[k*BITDEPTH +: BITDEPTH]};
    assign w_fb = out_q ? c_H : -c_H;
    assign out_o[k] = out_q;

    // Integrator sums with clamping to each integrator's signed range
    always_comb begin
      w_s1 = {{(c_SW-c_W1){i1_q[c_W1-1]}}, i1_q} + w_x - w_fb;
      if (w_s1 > c_I1_MAX)      w_c1 = c_I1_MAX;
      else if (w_s1 < c_I1_MIN) w_c1 = c_I1_MIN;
      else                      w_c1 = w_s1;
      i1_d = w_c1[c_W1-1:0];
      w_s2 = {{(c_SW-c_W2){i2_q[c_W2-1]}}, i2_q}
           + {{(c_SW-c_W1){i1_d[c_W1-1]}}, i1_d} - w_fb;
      if (w_s2 > c_I2_MAX)      w_c2 = c_I2_MAX;
      else if (w_s2 < c_I2_MIN) w_c2 = c_I2_MIN;
      else                      w_c2 = w_s2;
      i2_d = w_c2[c_W2-1:0];
      if (ORDER == 1) out_d = ~i1_d[c_W1-1];
      else            out_d = ~i2_d[c_W2-1];
    end

    // Modulator state advances only on enabled steps
    always_ff @(posedge clk) begin
      if (rst) begin
        i1_q  <= '0;
        i2_q  <= '0;
        out_q <= 1'b0;
      end else if (en_i) begin
        i1_q  <= i1_d;
        i2_q  <= i2_d;
        out_q <= out_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_dac_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_dac_multi
//  Function : Self-checking bench for sd_dac_multi, first- and second-order
//             instances side by side, against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sd_dac_multi;

  localparam int B   = 12;
  localparam int NC  = 2;
  localparam int OSR = 4;
  localparam int H   = 2048;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            pcm_valid = 1'b0;
  logic            underrun_clr = 1'b0;
  logic [NC*B-1:0] pcm_data = '0;
  logic            ready1, ready2, ur1, ur2;
  logic [NC-1:0]   out1, out2;

  always #5 clk = ~clk;

  sd_dac_multi #(.BITDEPTH(B), .NCHAN(NC), .ORDER(1), .OSR(OSR)) u_dut1 (
    .clk(clk), .rst(rst), .en_i(en), .pcm_valid_i(pcm_valid),
    .pcm_ready_o(ready1), .pcm_data_i(pcm_data), .underrun_o(ur1),
    .underrun_clr_i(underrun_clr), .out_o(out1));

  sd_dac_multi #(.BITDEPTH(B), .NCHAN(NC), .ORDER(2), .OSR(OSR)) u_dut2 (
    .clk(clk), .rst(rst), .en_i(en), .pcm_valid_i(pcm_valid),
    .pcm_ready_o(ready2), .pcm_data_i(pcm_data), .underrun_o(ur2),
    .underrun_clr_i(underrun_clr), .out_o(out2));

  int n_pass = 0;
  int n_total = 0;

  // Reference state: index 0 models ORDER=1, index 1 models ORDER=2
  int m_i1[2][NC];
  int m_i2[2][NC];
  bit m_out[2][NC];
  int m_act[NC];
  int m_pend[NC];
  bit m_pf;
  bit m_ur;
  int m_ocnt;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  function automatic int sat(input int v, input int bits);
    int mx, mn;
    mx = (1 << (bits - 1)) - 1;
    mn = -(1 << (bits - 1));
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  function automatic int chan(input logic [NC*B-1:0] d, input int k);
    logic [B-1:0] v;
    v = d[k*B +: B];
    return int'($signed(v));
  endfunction

  function automatic logic [NC*B-1:0] mkframe(input int a, input int b);
    logic [NC*B-1:0] f;
    f = '0;
    f[B-1:0]   = a[B-1:0];
    f[2*B-1:B] = b[B-1:0];
    return f;
  endfunction

  function automatic int mpack(input int o);
    int r;
    r = 0;
    for (int k = 0; k < NC; k++) if (m_out[o][k]) r += (1 << k);
    return r;
  endfunction

  // Advance the reference by one clock using the inputs currently driven
  task automatic model_update();
    bit tick, acc;
    int x, fb, n1, n2;
    if (rst) begin
      for (int o = 0; o < 2; o++)
        for (int k = 0; k < NC; k++) begin
          m_i1[o][k] = 0; m_i2[o][k] = 0; m_out[o][k] = 0;
        end
      for (int k = 0; k < NC; k++) begin m_act[k] = 0; m_pend[k] = 0; end
      m_pf = 0; m_ur = 0; m_ocnt = 0;
      return;
    end
    tick = en && (m_ocnt == OSR - 1);
    acc  = pcm_valid && !m_pf;
    if (en) begin
      for (int o = 0; o < 2; o++)
        for (int k = 0; k < NC; k++) begin
          x  = m_act[k];
          fb = m_out[o][k] ? H : -H;
          n1 = sat(m_i1[o][k] + x - fb, B + 2);
          m_i1[o][k] = n1;
          if (o == 0) m_out[o][k] = (n1 >= 0);
          else begin
            n2 = sat(m_i2[o][k] + n1 - fb, B + 4);
            m_i2[o][k] = n2;
            m_out[o][k] = (n2 >= 0);
          end
        end
    end
    if (tick && !m_pf && !acc) m_ur = 1;
    else if (underrun_clr) m_ur = 0;
    if (tick) begin
      if (m_pf) begin
        for (int k = 0; k < NC; k++) m_act[k] = m_pend[k];
        m_pf = 0;
      end else if (acc) begin
        for (int k = 0; k < NC; k++) m_act[k] = chan(pcm_data, k);
      end
    end else if (acc) begin
      for (int k = 0; k < NC; k++) m_pend[k] = chan(pcm_data, k);
      m_pf = 1;
    end
    if (en) m_ocnt = (m_ocnt + 1) % OSR;
  endtask

  // One clock: update the model, let the DUTs clock, compare just after the edge
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("ready1", ready1, !m_pf);
    chk("ready2", ready2, !m_pf);
    chk("underrun1", ur1, m_ur);
    chk("underrun2", ur2, m_ur);
    chk("out_order1", out1, mpack(0));
    chk("out_order2", out2, mpack(1));
  endtask

  task automatic do_reset();
    rst = 1; en = 0; pcm_valid = 0; underrun_clr = 0;
    step();
    rst = 0;
  endtask

  // Advance with en=1 until the next cycle is a tick, bounded
  task automatic to_tick_cycle();
    int n;
    n = 0;
    en = 1;
    while (m_ocnt != OSR - 1 && n < 2 * OSR) begin step(); n++; end
    chk("tick_align_timeout", (m_ocnt == OSR - 1) ? 1 : 0, 1);
  endtask

  // Load a DC frame after reset and count ones per instance over 4096 steps
  task automatic density(input int xv, input int lo, input int hi);
    int c1, c2;
    do_reset();
    en = 1; pcm_valid = 1; pcm_data = mkframe(xv, xv);
    step();
    pcm_valid = 0;
    to_tick_cycle();
    step();
    c1 = 0; c2 = 0;
    for (int i = 0; i < 4096; i++) begin
      step();
      c1 += int'(out1[0]) + int'(out1[1]);
      c2 += int'(out2[0]) + int'(out2[1]);
    end
    c1 = c1 / 2; c2 = c2 / 2;
    chk($sformatf("density1_x%0d_inrange", xv), (c1 >= lo && c1 <= hi) ? 1 : 0, 1);
    chk($sformatf("density2_x%0d_inrange", xv), (c2 >= lo && c2 <= hi) ? 1 : 0, 1);
    if (c1 < lo || c1 > hi) $display("  order1 ones=%0d window %0d..%0d", c1, lo, hi);
    if (c2 < lo || c2 > hi) $display("  order2 ones=%0d window %0d..%0d", c2, lo, hi);
  endtask

  typedef struct {
    bit rst;
    bit en;
    bit valid;
    int exp_out1;
    int exp_out2;
    bit exp_ready;
    bit exp_ur;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int k, nacc, good1, good2;

    // Reset then act=0 with zero frames supplied: idle-tone patterns
    tbl[0] = '{1, 0, 1, 0, 0, 1, 0};
    tbl[1] = '{1, 1, 1, 0, 0, 1, 0};
    tbl[2] = '{0, 1, 1, 3, 3, 0, 0};
    tbl[3] = '{0, 1, 1, 3, 3, 0, 0};
    tbl[4] = '{0, 1, 1, 0, 0, 0, 0};
    tbl[5] = '{0, 1, 1, 3, 3, 1, 0};
    tbl[6] = '{0, 1, 1, 0, 0, 0, 0};
    tbl[7] = '{0, 1, 1, 3, 0, 0, 0};
    tbl[8] = '{0, 1, 1, 0, 3, 0, 0};
    pcm_data = '0;
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; pcm_valid = tbl[i].valid;
      step();
      chk($sformatf("tbl%0d_out1", i), out1, tbl[i].exp_out1);
      chk($sformatf("tbl%0d_out2", i), out2, tbl[i].exp_out2);
      chk($sformatf("tbl%0d_ready", i), ready1, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_underrun", i), ur1, tbl[i].exp_ur);
    end
    pcm_valid = 0;

    // DC density for both orders
    density(1024, 3070, 3074);
    density(-2048, 0, 2);
    density(2047, 4090, 4096);

    // Handshake: frames held on valid, one accepted per sample period
    do_reset();
    en = 1; pcm_valid = 1; k = 1; pcm_data = mkframe(k, -k);
    nacc = 0;
    for (int i = 0; i < 48; i++) begin
      if (pcm_valid && ready1) begin
        if (i >= 8) nacc++;
        step();
        k++;
        pcm_data = mkframe(k, -k);
      end else step();
    end
    chk("handshake_accepts_per_40", nacc, 10);
    chk("handshake_no_underrun", ur1, 0);

    // Underrun: starve for two ticks, clear on tick (set wins), clear off tick
    pcm_valid = 0;
    for (int i = 0; i < 12; i++) step();
    chk("underrun_set", ur1, 1);
    to_tick_cycle();
    underrun_clr = 1;
    step();
    underrun_clr = 0;
    chk("underrun_clr_on_tick_loses", ur1, 1);
    underrun_clr = 1;
    step();
    underrun_clr = 0;
    chk("underrun_clr_off_tick", ur1, 0);

    // Bypass: frame offered on the tick cycle with an empty buffer
    to_tick_cycle();
    pcm_valid = 1; pcm_data = mkframe(777, -777);
    step();
    pcm_valid = 0;
    chk("bypass_ready_stays", ready1, 1);
    chk("bypass_no_underrun", ur1, 0);
    for (int i = 0; i < 20; i++) step();

    // Saturation: long full-scale negative, then full-scale positive
    do_reset();
    en = 1; pcm_valid = 1; pcm_data = mkframe(-2048, -2048);
    step();
    pcm_valid = 0;
    for (int i = 0; i < 10000; i++) step();
    pcm_valid = 1; pcm_data = mkframe(2047, 2047);
    step();
    pcm_valid = 0;
    to_tick_cycle();
    step();
    good1 = 0; good2 = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (i >= 32 && out1 == 2'b11) good1++;
      if (i >= 32 && out2 == 2'b11) good2++;
    end
    chk("sat_recover_order1", good1, 32);
    chk("sat_recover_order2", good2, 32);

    // Reset mid-stream restores reset values
    pcm_valid = 1; pcm_data = mkframe(100, 200);
    step();
    rst = 1;
    step();
    rst = 0; pcm_valid = 0;
    chk("midrst_out1", out1, 0);
    chk("midrst_out2", out2, 0);
    chk("midrst_ready", ready1, 1);
    chk("midrst_underrun", ur1, 0);

    // Randomised traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 599) == 0);
      en           = ($urandom_range(0, 3) != 0);
      pcm_valid    = ($urandom_range(0, 2) != 0);
      underrun_clr = ($urandom_range(0, 15) == 0);
      pcm_data     = mkframe(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
